// File: rtl/game_state_manager.sv
// game_state_manager: lives, BCD score, invulnerability/blink and start/play/over/win FSM
module game_state_manager #(
  parameter int INIT_LIVES    = 3,
  parameter int MAX_LIVES     = 5,
  parameter int INVULN_FRAMES = 60,
  parameter int WIN_SCORE     = 20
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       start_game,
  input  logic       hit_pulse,
  input  logic       bonus_hit,
  output logic [2:0] lives,
  output logic [3:0] score_hundreds,
  output logic [3:0] score_tens,
  output logic [3:0] score_ones,
  output logic [2:0] game_state,
  output logic       game_over,
  output logic       game_won,
  output logic       player_visible,
  output logic       freeze
);
  typedef enum logic [2:0] {IDLE = 3'd0, PLAY = 3'd1, INVULN = 3'd2, OVER = 3'd3, WON = 3'd4} state_t;
  state_t state_q, state_d;
  logic [2:0] lives_q, lives_d, blink_q, blink_d, lives_b;
  logic [3:0] h_q, h_d, t_q, t_d, o_q, o_d, h_n, t_n, o_n;
  logic [7:0] inv_q, inv_d;
  logic       flag_q, flag_d, start_prev_q;
  logic       start_rise, active, bonus_acc, hit_act, win, o9, t9, sat;
  logic [9:0] score_bin;
  assign start_rise = start_game & ~start_prev_q;
  assign active     = (state_q == PLAY) || (state_q == INVULN);
  assign bonus_acc  = active & bonus_hit & ~flag_q;
  assign hit_act    = (state_q == PLAY) & hit_pulse;
  assign lives_b    = !bonus_acc ? lives_q : (lives_q >= 3'(MAX_LIVES)) ? 3'(MAX_LIVES) : lives_q + 3'd1;
  assign o9  = o_q == 4'd9;
  assign t9  = t_q == 4'd9;
  assign sat = o9 & t9 & (h_q == 4'd9);
  assign o_n = sat ? o_q : o9 ? 4'd0 : o_q + 4'd1;
  assign t_n = sat ? t_q : o9 ? (t9 ? 4'd0 : t_q + 4'd1) : t_q;
  assign h_n = sat ? h_q : (o9 & t9) ? h_q + 4'd1 : h_q;
  assign score_bin = 10'(h_q) * 10'd100 + 10'(t_q) * 10'd10 + 10'(o_q);
  assign win = score_bin >= 10'(WIN_SCORE);
  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    h_d     = h_q;
    t_d     = t_q;
    o_d     = o_q;
    inv_d   = inv_q;
    blink_d = blink_q;
    // a same-cycle acceptance re-arms the flag even on the frame boundary
    flag_d  = bonus_acc | (flag_q & ~startOfFrame);
    if (!active) begin
      if (start_rise) begin
        state_d = PLAY;
        lives_d = 3'(INIT_LIVES);
        {h_d, t_d, o_d} = 12'h000;
      end
    end else begin
      lives_d = lives_b;
      if (bonus_acc) {h_d, t_d, o_d} = {h_n, t_n, o_n};
      if (state_q == INVULN && startOfFrame) begin
        inv_d   = inv_q - 8'd1;
        blink_d = blink_q + 3'd1;
        if (inv_q == 8'd1) state_d = PLAY;
      end
      // a hit is fatal only without a same-cycle bonus; death outranks the win check
      if (hit_act) begin
        if (!bonus_acc && lives_q == 3'd1) begin
          lives_d = 3'd0;
          state_d = OVER;
        end else begin
          lives_d = lives_b - 3'd1;
          inv_d   = 8'(INVULN_FRAMES);
          blink_d = 3'd0;
          state_d = INVULN;
        end
      end else if (win) state_d = WON;
    end
  end
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      state_q      <= IDLE;
      lives_q      <= 3'(INIT_LIVES);
      {h_q, t_q, o_q} <= 12'h000;
      inv_q        <= 8'd0;
      blink_q      <= 3'd0;
      flag_q       <= 1'b0;
      start_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lives_q      <= lives_d;
      {h_q, t_q, o_q} <= {h_d, t_d, o_d};
      inv_q        <= inv_d;
      blink_q      <= blink_d;
      flag_q       <= flag_d;
      start_prev_q <= start_game;
    end
  assign lives          = lives_q;
  assign score_hundreds = h_q;
  assign score_tens     = t_q;
  assign score_ones     = o_q;
  assign game_state     = state_q;
  assign game_over      = state_q == OVER;
  assign game_won       = state_q == WON;
  assign freeze         = (state_q == IDLE) || (state_q == OVER) || (state_q == WON);
  assign player_visible = (state_q == INVULN) ? ~blink_q[2] : (state_q != OVER);
endmodule

// File: tb/tb_game_state_manager.sv
// tb_game_state_manager: directed checks of lives, score, invulnerability and game FSM
module tb_game_state_manager;
  logic clk = 0, resetN = 0, sof = 0, start = 0, hit = 0, bonus = 0;
  logic [2:0] lives, gs;
  logic [3:0] sh, st, so;
  logic go, gw, vis, frz;
  int passed = 0, total = 0;
  game_state_manager dut (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .start_game(start),
    .hit_pulse(hit), .bonus_hit(bonus), .lives(lives), .score_hundreds(sh),
    .score_tens(st), .score_ones(so), .game_state(gs), .game_over(go),
    .game_won(gw), .player_visible(vis), .freeze(frz)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      sof = 1;
      cyc();
      sof = 0;
      cyc();
      cyc();
    end
  endtask
  task automatic pulse_hit();
    hit = 1;
    cyc();
    hit = 0;
  endtask
  task automatic pulse_start();
    start = 1;
    cyc();
    start = 0;
    cyc();
  endtask
  initial begin
    cyc();
    cyc();
    chk("rst_state", gs, 0);
    chk("rst_lives", lives, 3);
    chk("rst_score", {sh, st, so}, 'h000);
    chk("rst_over", go, 0);
    chk("rst_won", gw, 0);
    chk("rst_vis", vis, 1);
    chk("rst_freeze", frz, 1);
    resetN = 1;
    cyc();
    start = 1;
    cyc();
    chk("start_state", gs, 1);
    chk("start_lives", lives, 3);
    chk("start_freeze", frz, 0);
    cyc();
    start = 0;
    cyc();
    pulse_hit();
    chk("hit1_lives", lives, 2);
    chk("hit1_state", gs, 2);
    chk("hit1_vis", vis, 1);
    frames(4);
    chk("blink_off", vis, 0);
    frames(4);
    chk("blink_on", vis, 1);
    frames(2);
    pulse_hit();
    chk("inv_ignore_hit", lives, 2);
    frames(49);
    chk("inv_59", gs, 2);
    frames(1);
    chk("inv_60", gs, 1);
    chk("inv_end_vis", vis, 1);
    pulse_hit();
    chk("hit2_lives", lives, 1);
    frames(60);
    chk("hit2_back", gs, 1);
    pulse_hit();
    chk("death_lives", lives, 0);
    chk("death_state", gs, 3);
    chk("death_over", go, 1);
    chk("death_vis", vis, 0);
    chk("death_freeze", frz, 1);
    bonus = 1;
    hit = 1;
    frames(2);
    bonus = 0;
    hit = 0;
    chk("over_score", {sh, st, so}, 'h000);
    chk("over_lives", lives, 0);
    pulse_start();
    chk("restart_state", gs, 1);
    chk("restart_lives", lives, 3);
    chk("restart_over", go, 0);
    bonus = 1;
    cyc();
    chk("bonus1_score", {sh, st, so}, 'h001);
    chk("bonus1_lives", lives, 4);
    frames(4);
    bonus = 0;
    chk("bonus5_score", {sh, st, so}, 'h005);
    chk("bonus5_lives", lives, 5);
    for (int i = 0; i < 14; i++) begin
      frames(1);
      bonus = 1;
      cyc();
      bonus = 0;
    end
    chk("score19", {sh, st, so}, 'h019);
    chk("score19_state", gs, 1);
    frames(1);
    bonus = 1;
    cyc();
    bonus = 0;
    chk("score20", {sh, st, so}, 'h020);
    chk("score20_state", gs, 1);
    cyc();
    chk("won_state", gs, 4);
    chk("won_flag", gw, 1);
    chk("won_freeze", frz, 1);
    chk("won_vis", vis, 1);
    frames(1);
    bonus = 1;
    hit = 1;
    cyc();
    bonus = 0;
    hit = 0;
    chk("won_score", {sh, st, so}, 'h020);
    chk("won_lives", lives, 5);
    chk("won_hold", gs, 4);
    pulse_start();
    chk("replay_state", gs, 1);
    chk("replay_score", {sh, st, so}, 'h000);
    chk("replay_lives", lives, 3);
    pulse_hit();
    frames(60);
    pulse_hit();
    frames(60);
    chk("one_life", lives, 1);
    chk("one_life_state", gs, 1);
    hit = 1;
    bonus = 1;
    cyc();
    hit = 0;
    bonus = 0;
    chk("hb_lives", lives, 1);
    chk("hb_state", gs, 2);
    chk("hb_over", go, 0);
    chk("hb_score", {sh, st, so}, 'h001);
    frames(1);
    #2 resetN = 0;
    #1;
    chk("arst_state", gs, 0);
    chk("arst_lives", lives, 3);
    chk("arst_score", {sh, st, so}, 'h000);
    chk("arst_vis", vis, 1);
    chk("arst_freeze", frz, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
